// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, default base address.
// Pure declarations; no logic, no latency, no flow control.
package dm_pkg;

    typedef enum logic [1:0] {
        DM_SIZE_BYTE = 2'd0,
        DM_SIZE_HALF = 2'd1,
        DM_SIZE_WORD = 2'd2,
        DM_SIZE_BAD  = 2'd3
    } dm_size_e;

    typedef enum logic [1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

    localparam logic [31:0] DM_BASE_ADDR_DEFAULT = 32'h2000_0000;

endpackage

// File: rtl/dm_if.sv
// Data-memory request/response bundle between the core's address mux (master) and the responder (slave).
// Request is held by the master until a single-cycle mem_ready pulse.
interface dm_if;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_fault;

    modport master (
        output mem_addr, mem_read, mem_write, mem_size, mem_wdata,
        input  mem_rdata, mem_ready, mem_fault
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_size, mem_wdata,
        output mem_rdata, mem_ready, mem_fault
    );

endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering for loads/stores plus alignment check (alignment faults only with DM_ALIGN_FAULT_EN).
// Purely combinational: zero latency, no flow control.
module dm_lane_align
    import dm_pkg::*;
(
    input  dm_size_e    size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wmerged_o,
    output logic [31:0] rdata_o,
    output logic        align_err_o
);

    logic [31:0] wlanes;

    always_comb begin
        be_o        = 4'b0000;
        rdata_o     = 32'h0;
        align_err_o = 1'b0;
        wlanes      = wdata_i;
        case (size_i)
            DM_SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {24'h0, word_i[8*addr_lo_i +: 8]};
                wlanes  = {4{wdata_i[7:0]}};
            end
            DM_SIZE_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = {16'h0, (addr_lo_i[1] ? word_i[31:16] : word_i[15:0])};
                wlanes  = {2{wdata_i[15:0]}};
`ifdef DM_ALIGN_FAULT_EN
                align_err_o = addr_lo_i[0];
`endif
            end
            DM_SIZE_WORD: begin
                be_o    = 4'b1111;
                rdata_o = word_i;
`ifdef DM_ALIGN_FAULT_EN
                align_err_o = |addr_lo_i;
`endif
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            wmerged_o[8*i +: 8] = be_o[i] ? wlanes[8*i +: 8] : word_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: range/size/conflict (and, with DM_ALIGN_FAULT_EN, alignment) checked loads/stores.
// Latency WAIT_STATES+1 cycles to a one-cycle mem_ready; one access per WAIT_STATES+2 cycles, request held by master.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    dm_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    dm_state_e   state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;

    logic [31:0] mem_q [DEPTH];

    // With zero wait states the access happens on the IDLE edge, before anything is latched.
    logic                  in_idle;
    logic [31:0]           acc_addr;
    logic [1:0]            acc_size;
    logic [31:0]           acc_wdata;
    logic                  acc_rd;
    logic                  acc_wr;
    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] widx;
    logic                  range_err;
    logic                  acc_fault;
    logic                  access;
    logic                  mem_we;

    logic [3:0]  be;
    logic [31:0] wmerged;
    logic [31:0] lane_rdata;
    logic        align_err;

    assign in_idle   = (state_q == DM_IDLE);
    assign acc_addr  = in_idle ? bus.mem_addr  : addr_q;
    assign acc_size  = in_idle ? bus.mem_size  : size_q;
    assign acc_wdata = in_idle ? bus.mem_wdata : wdata_q;
    assign acc_rd    = in_idle ? bus.mem_read  : rd_q;
    assign acc_wr    = in_idle ? bus.mem_write : wr_q;

    assign offset    = acc_addr - BASE_ADDR;
    assign widx      = offset[ADDR_WIDTH+1:2];
    assign range_err = |offset[31:ADDR_WIDTH+2];
    assign acc_fault = (acc_rd & acc_wr) | (acc_size == DM_SIZE_BAD) | range_err | align_err;

    dm_lane_align u_lane (
        .size_i      (dm_size_e'(acc_size)),
        .addr_lo_i   (offset[1:0]),
        .wdata_i     (acc_wdata),
        .word_i      (mem_q[widx]),
        .be_o        (be),
        .wmerged_o   (wmerged),
        .rdata_o     (lane_rdata),
        .align_err_o (align_err)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        ready_d = 1'b0;
        access  = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (bus.mem_read | bus.mem_write) begin
                    addr_d  = bus.mem_addr;
                    size_d  = bus.mem_size;
                    wdata_d = bus.mem_wdata;
                    rd_d    = bus.mem_read;
                    wr_d    = bus.mem_write;
                    wcnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        state_d = DM_WAIT;
                    end else begin
                        state_d = DM_RESP;
                        access  = 1'b1;
                    end
                end
            end
            DM_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) begin
                    state_d = DM_RESP;
                    access  = 1'b1;
                end
            end
            DM_RESP: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
        if (access) begin
            ready_d = 1'b1;
            fault_d = acc_fault;
            rdata_d = (acc_fault | acc_wr) ? 32'h0 : lane_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DM_IDLE;
            wcnt_q  <= 4'd0;
            addr_q  <= 32'h0;
            size_q  <= 2'd0;
            wdata_q <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Array is not reset; rst_n gates the strobe so a reset never lands a write.
    assign mem_we = access & acc_wr & ~acc_fault & rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wmerged[8*i +: 8];
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_fault = fault_q;

endmodule
